// File: rtl/sm_debug_dump.sv
// rtl/sm_debug_dump.sv - debug dump initiator: scans CPU registers then data RAM
// and streams them as a byte frame (header, MSB-first words, XOR checksum).
module sm_debug_dump #(
  parameter int          REG_COUNT = 32,
  parameter int          RAM_WORDS = 32,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [4:0]  ramAddrB,
  input  logic [31:0] ramDataB,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ADDR, S_LOAD, S_SEND, S_SUM, S_DONE
  } state_t;

  localparam logic [5:0] LAST_REG = 6'(REG_COUNT - 1);
  localparam logic [5:0] LAST_RAM = 6'(RAM_WORDS - 1);

  state_t      r_state, w_state;
  logic [5:0]  r_index, w_index;
  logic [1:0]  r_cnt, w_cnt;
  logic [7:0]  r_sum, w_sum;
  logic        r_phase, w_phase;
  logic [31:0] r_shift, w_shift;
  logic [7:0]  r_tx_data, w_tx_data;
  logic        r_tx_valid, w_tx_valid;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic [4:0]  r_reg_addr, w_reg_addr;
  logic [4:0]  r_ram_addr, w_ram_addr;
  logic        w_hs;
  logic        w_last;
  logic [31:0] w_load_data;

  assign w_hs        = r_tx_valid & tx_ready;
  assign w_last      = r_phase ? (r_index == LAST_RAM) : (r_index == LAST_REG);
  assign w_load_data = r_phase ? ramDataB : regData;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_phase    <= 1'b0;
      r_shift    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_reg_addr <= '0;
      r_ram_addr <= '0;
    end else begin
      r_state    <= w_state;
      r_index    <= w_index;
      r_cnt      <= w_cnt;
      r_sum      <= w_sum;
      r_phase    <= w_phase;
      r_shift    <= w_shift;
      r_tx_data  <= w_tx_data;
      r_tx_valid <= w_tx_valid;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_reg_addr <= w_reg_addr;
      r_ram_addr <= w_ram_addr;
    end
  end

  // Every output register is loaded from its next-state value, so outputs
  // line up with the state they belong to without a combinational path.
  always_comb begin
    w_state    = r_state;
    w_index    = r_index;
    w_cnt      = r_cnt;
    w_sum      = r_sum;
    w_phase    = r_phase;
    w_shift    = r_shift;
    w_tx_data  = r_tx_data;
    w_tx_valid = r_tx_valid;
    w_reg_addr = r_reg_addr;
    w_ram_addr = r_ram_addr;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state    = S_HDR;
          w_sum      = '0;
          w_index    = '0;
          w_phase    = 1'b0;
          w_tx_valid = 1'b1;
          w_tx_data  = HEADER;
        end
      end
      S_HDR: begin
        if (w_hs) begin
          w_sum      = r_sum ^ HEADER;
          w_tx_valid = 1'b0;
          w_state    = S_ADDR;
        end
      end
      S_ADDR: w_state = S_LOAD;
      S_LOAD: begin
        // Address was presented for all of ADDR, so a one-cycle RAM lag has settled.
        w_shift    = w_load_data;
        w_tx_data  = w_load_data[31:24];
        w_tx_valid = 1'b1;
        w_cnt      = '0;
        w_state    = S_SEND;
      end
      S_SEND: begin
        if (w_hs) begin
          w_sum     = r_sum ^ r_tx_data;
          w_shift   = {r_shift[23:0], 8'h00};
          w_tx_data = r_shift[23:16];
          w_cnt     = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            if (!w_last) begin
              w_index    = r_index + 6'd1;
              w_tx_valid = 1'b0;
              w_state    = S_ADDR;
            end else if (!r_phase) begin
              w_phase    = 1'b1;
              w_index    = '0;
              w_tx_valid = 1'b0;
              w_state    = S_ADDR;
            end else begin
              w_tx_data = r_sum ^ r_tx_data;
              w_state   = S_SUM;
            end
          end
        end
      end
      S_SUM: begin
        if (w_hs) begin
          w_tx_valid = 1'b0;
          w_state    = S_DONE;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    if (w_state == S_ADDR) begin
      if (w_phase) w_ram_addr = w_index[4:0];
      else         w_reg_addr = w_index[4:0];
    end

    w_busy = (w_state != S_IDLE);
    w_done = (w_state == S_DONE);
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign regAddr  = r_reg_addr;
  assign ramAddrB = r_ram_addr;
  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_sm_debug_dump.sv
// tb/tb_sm_debug_dump.sv - directed bench for sm_debug_dump (default and
// small-parameter instances).
module tb_sm_debug_dump;

  logic        clk = 1'b0;
  logic        rst, start, tx_ready;
  logic        busy, done, tx_valid;
  logic [4:0]  regAddr, ramAddrB;
  logic [31:0] regData, ramDataB;
  logic [7:0]  tx_data;

  logic        s_start, s_tx_ready, s_busy, s_done, s_tx_valid;
  logic [4:0]  s_regAddr, s_ramAddrB;
  logic [31:0] s_regData, s_ramDataB;
  logic [7:0]  s_tx_data;

  always #5 clk = ~clk;

  sm_debug_dump u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .regAddr(regAddr), .regData(regData), .ramAddrB(ramAddrB), .ramDataB(ramDataB),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  sm_debug_dump #(.REG_COUNT(1), .RAM_WORDS(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .regAddr(s_regAddr), .regData(s_regData), .ramAddrB(s_ramAddrB), .ramDataB(s_ramDataB),
    .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(s_tx_ready)
  );

  // CPU model: combinational register read, RAM with one cycle of read latency
  always_comb regData = (regAddr == 5'd0) ? 32'h0000_0010 : {27'd0, regAddr};
  always @(posedge clk) ramDataB <= 32'hDEAD_0000 + {27'd0, ramAddrB};

  int          checks = 0, errors = 0, cyc = 0;
  int          nbytes, ndone, done_cyc, t_start;
  int          s_nbytes, s_ndone, s_done_cyc;
  bit          bp = 1'b0;
  bit          stall_pending = 1'b0;
  logic [7:0]  stall_data;
  logic [7:0]  got   [0:299];
  logic [7:0]  s_got [0:31];
  logic [7:0]  exp_b [0:257];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (stall_pending) begin
      chk("stall_valid", {31'd0, tx_valid}, 32'd1);
      chk("stall_data", {24'd0, tx_data}, {24'd0, stall_data});
    end
    tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    stall_pending = (tx_valid === 1'b1) && !tx_ready;
    stall_data = tx_data;
    if (tx_valid === 1'b1 && tx_ready) begin
      if (nbytes < 300) got[nbytes] = tx_data;
      nbytes++;
    end
    if (done === 1'b1) begin ndone++; done_cyc = cyc; end
    if (s_tx_valid === 1'b1 && s_tx_ready) begin
      if (s_nbytes < 32) s_got[s_nbytes] = s_tx_data;
      s_nbytes++;
    end
    if (s_done === 1'b1) begin s_ndone++; s_done_cyc = cyc; end
  endtask

  task automatic clear();
    nbytes = 0; ndone = 0; done_cyc = 0;
    for (int i = 0; i < 300; i++) got[i] = 8'hxx;
  endtask

  task automatic run_frame(input bit busy_pulses, input int bound);
    int t;
    t = 0;
    t_start = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    while (ndone == 0 && t < bound) begin
      start = busy_pulses && ((cyc - t_start) == 50 || (cyc - t_start) == 200);
      step();
      t++;
    end
    start = 1'b0;
    chk("done_seen", ndone, 1);
    repeat (8) step();
  endtask

  task automatic compare_frame(input string tag);
    chk({tag, "_len"}, nbytes, 258);
    chk({tag, "_ndone"}, ndone, 1);
    for (int i = 0; i < 258; i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_b[i]});
  endtask

  initial begin
    exp_b[0] = 8'hA5;
    for (int w = 0; w < 64; w++) begin
      logic [31:0] word;
      if (w < 32) word = (w == 0) ? 32'h10 : 32'(w);
      else        word = 32'hDEAD_0000 + 32'(w - 32);
      for (int b = 0; b < 4; b++) exp_b[1 + 4*w + b] = word[31 - 8*b -: 8];
    end
    // header A5 ^ PC low byte 10; every other byte column cancels pairwise
    exp_b[257] = 8'hB5;

    s_regData = '0; s_ramDataB = '0; s_tx_ready = 1'b1; s_start = 1'b0;
    s_nbytes = 0; s_ndone = 0; s_done_cyc = 0;
    clear();

    // reset with start held high
    rst = 1'b1; start = 1'b1; tx_ready = 1'b0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_regaddr", {27'd0, regAddr}, 32'd0);
    chk("rst_ramaddr", {27'd0, ramAddrB}, 32'd0);
    chk("rst_txdata", {24'd0, tx_data}, 32'd0);
    rst = 1'b0; start = 1'b0;
    step(); step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // full dump, sink always ready
    clear();
    run_frame(1'b0, 1000);
    compare_frame("full");
    chk("full_latency", done_cyc - t_start, 387);
    chk("full_busy_after", {31'd0, busy}, 32'd0);

    // random backpressure
    clear();
    bp = 1'b1;
    run_frame(1'b0, 5000);
    bp = 1'b0;
    compare_frame("bp");

    // start pulses while busy are ignored
    clear();
    run_frame(1'b1, 1000);
    compare_frame("busy_start");

    // reset while the third byte of register 5 is presented
    clear();
    begin
      int t;
      t = 0;
      start = 1'b1; step(); start = 1'b0;
      while (nbytes < 24 && t < 300) begin step(); t++; end
    end
    chk("mid_reached", nbytes, 24);
    chk("mid_reg4_lsb", {24'd0, got[20]}, 32'h04);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    begin
      int n;
      n = nbytes;
      repeat (10) step();
      chk("mid_quiet", nbytes, n);
    end
    clear();
    run_frame(1'b0, 1000);
    compare_frame("fresh");

    // small instance: 1 register, 2 RAM words, all data zero
    s_start = 1'b1; t_start = cyc; step(); s_start = 1'b0;
    begin
      int t;
      t = 0;
      while (s_ndone == 0 && t < 200) begin step(); t++; end
    end
    repeat (5) step();
    chk("small_len", s_nbytes, 14);
    chk("small_ndone", s_ndone, 1);
    chk("small_latency", s_done_cyc - t_start, 21);
    chk("small_hdr", {24'd0, s_got[0]}, 32'hA5);
    for (int i = 1; i < 13; i++) chk($sformatf("small_byte%0d", i), {24'd0, s_got[i]}, 32'h00);
    chk("small_sum", {24'd0, s_got[13]}, 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_debug_dump.md
Name: sm_debug_dump

Overview:
- Initiator on the CPU debug read ports (register port regAddr/regData, RAM port B ramAddrB/ramDataB).
- On a start request it scans all debug-readable registers (index 0 returns PC), then the data RAM.
- Each 32-bit word is serialised into a byte stream with valid/ready handshake, framed by a header byte and an XOR checksum byte.
- Sits beside sm_cpu at top level and feeds a byte sink (UART transmitter or testbench monitor).

Parameters:
- REG_COUNT, 32, number of register indices dumped (0..REG_COUNT-1); range 1..32.
- RAM_WORDS, 32, number of RAM words dumped (0..RAM_WORDS-1); range 1..32.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  dump request; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse in DONE state.
- regAddr  out  5  debug register index to CPU.
- regData  in  32  debug register value (combinational from regAddr).
- ramAddrB  out  5  debug RAM word address.
- ramDataB  in  32  debug RAM data; may lag address by up to one cycle.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte when tx_valid & tx_ready.

Behaviour:
- Reset (synchronous, active-high, one clk edge with rst=1): state IDLE; busy=0, done=0, tx_valid=0, tx_data=0, regAddr=0, ramAddrB=0; index, byte counter and checksum cleared. Reset at any point aborts the frame; no further bytes are sent.
- All outputs are registered.
- States: IDLE, HDR, ADDR, LOAD, SEND, SUM, DONE.
- IDLE: start=1 -> HDR, checksum=0, index=0, phase=REG. start ignored in every other state.
- HDR: tx_valid=1, tx_data=HEADER. On handshake: checksum^=HEADER, go to ADDR.
- ADDR (1 cycle): phase REG drives regAddr=index; phase RAM drives ramAddrB=index. tx_valid=0.
- LOAD (1 cycle): capture regData or ramDataB into 32-bit shift register; byte counter=0; go to SEND.
- SEND: tx_valid=1, tx_data=shift[31:24] (MSB first). On handshake: checksum^=byte, shift<<=8, counter+1. After the 4th handshake:
  - phase REG, index<REG_COUNT-1 -> index+1, go to ADDR.
  - phase REG, last index -> phase=RAM, index=0, go to ADDR.
  - phase RAM, index<RAM_WORDS-1 -> index+1, go to ADDR.
  - phase RAM, last index -> SUM.
- SUM: tx_valid=1, tx_data=checksum (XOR of header and all data bytes). On handshake -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 on the next cycle -> IDLE.
- Handshake rules:
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without a handshake (except on reset).
  - tx_ready is ignored while tx_valid=0.
- Frame length = 2 + 4*(REG_COUNT+RAM_WORDS) bytes; 258 with defaults.
- Latency with tx_ready held 1:
  - start cycle, 1 header cycle, 6 cycles per word, 1 SUM cycle, 1 DONE cycle.
  - Defaults: 387 cycles from the cycle after start to the done pulse.
- Index counter is 6 bits; regAddr/ramAddrB take its low 5 bits.
- Back-to-back: start asserted in the cycle after DONE begins a new frame.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> busy=0, tx_valid=0, regAddr=0, ramAddrB=0, done=0.
- Full dump, tx_ready=1: PC=0x00000010, reg r_i=i, RAM word j=0xDEAD0000+j -> 258 bytes: A5, 00 00 00 10, 00 00 00 01, ... DE AD 00 1F, then XOR checksum; done pulses 387 cycles after start; exactly one done pulse.
- Backpressure: toggle tx_ready pseudo-randomly -> byte sequence identical to the previous test, tx_data stable during every stall, no byte dropped or duplicated.
- Start while busy: pulse start at cycles 50 and 200 of a frame -> single frame of 258 bytes, no restart.
- Reset mid-frame: assert rst during the third byte of register 5 -> tx_valid=0 next cycle, IDLE; a subsequent start produces a complete fresh frame beginning A5.
- Small parameters: REG_COUNT=1, RAM_WORDS=2, all data zero -> frame A5, 12 bytes of 00, checksum A5 (14 bytes total).
